// File: rtl/cwe1262_bank_wr_ctrl.sv
// Lockable register-bank write controller: two requesters, round-robin arbitration, one sticky lock.
// Latency: the write lands 2 edges after acceptance and its response follows in the next cycle; a rejected request responds 1 cycle earlier.
// Backpressure: a ready goes high only in IDLE for the granted requester; other requesters hold valid/addr/wdata.
module cwe1262_bank_wr_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [ADDR_W-1:0]          req0_addr,
  input  logic [DATA_W-1:0]          req0_wdata,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [ADDR_W-1:0]          req1_addr,
  input  logic [DATA_W-1:0]          req1_wdata,
  output logic                       req1_ready,
  input  logic                       lock_set,
  output logic                       lock,
  output logic [NUM_REGS*DATA_W-1:0] reg_bank,
  output logic                       resp_valid,
  output logic                       resp_id,
  output logic                       resp_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NREGS = (ADDR_W+1)'(NUM_REGS);

  logic [1:0]                 state;
  logic                       rr_ptr;
  logic                       id_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [DATA_W-1:0]          wdata_q;
  logic [NUM_REGS*DATA_W-1:0] bank_q;
  logic                       lock_q;

  logic                       gnt_id;
  logic                       accept;
  logic                       addr_oob;
  logic                       chk_err;

  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    req0_ready = (state == S_IDLE) && req0_valid && !gnt_id;
    req1_ready = (state == S_IDLE) && req1_valid && gnt_id;
    accept     = req0_ready || req1_ready;
    addr_oob   = ({1'b0, addr_q} >= NREGS);
    // A lock pulse landing in the check cycle must still block the write.
    chk_err    = lock_q || lock_set || addr_oob;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= 1'b0;
    end else if (lock_set) begin
      lock_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      id_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bank_q     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          if (accept) begin
            id_q    <= gnt_id;
            addr_q  <= gnt_id ? req1_addr : req0_addr;
            wdata_q <= gnt_id ? req1_wdata : req0_wdata;
            rr_ptr  <= ~gnt_id;
            state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_err) begin
            resp_valid <= 1'b1;
            resp_id    <= id_q;
            resp_err   <= 1'b1;
            state      <= S_RESP;
          end else begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          resp_valid <= 1'b1;
          resp_id    <= id_q;
          if (lock_set || lock_q) begin
            resp_err <= 1'b1;
          end else begin
            resp_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr_q == ADDR_W'(i)) begin
                bank_q[i*DATA_W +: DATA_W] <= wdata_q;
              end
            end
          end
          state <= S_RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign lock     = lock_q;
  assign reg_bank = bank_q;

endmodule

// File: doc/cwe1262_bank_wr_ctrl.md
Name: cwe1262_bank_wr_ctrl

Overview:
- Write controller for a lockable register bank of NUM_REGS entries, DATA_W bits each.
- Two requesters share one write port through a round-robin arbiter.
- One sticky lock bit gates writes to every entry alike. There is no per-entry exemption, and no address can bypass the lock.
- Each accepted request gets exactly one response: write done, or error.

Parameters:
- NUM_REGS, 4, number of bank entries (1..2**ADDR_W).
- DATA_W, 32, width of each entry.
- ADDR_W, 2, request address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has a pending write
- req0_addr  in  ADDR_W  requester 0 target entry
- req0_wdata  in  DATA_W  requester 0 write data
- req0_ready  out  1  requester 0 request accepted this cycle
- req1_valid  in  1  requester 1 has a pending write
- req1_addr  in  ADDR_W  requester 1 target entry
- req1_wdata  in  DATA_W  requester 1 write data
- req1_ready  out  1  requester 1 request accepted this cycle
- lock_set  in  1  one-cycle pulse that sets the sticky lock
- lock  out  1  current lock state
- reg_bank  out  NUM_REGS*DATA_W  flattened bank; entry i occupies bits [i*DATA_W +: DATA_W]
- resp_valid  out  1  one-cycle response pulse
- resp_id  out  1  requester that the response belongs to
- resp_err  out  1  1 means the request was rejected and nothing was written

Behaviour:
- Reset (rst=1 at a clock edge): all reg_bank entries become 0, lock=0, FSM goes to IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_err=0.
  - Reset mid-operation aborts the transaction: no write, no response.
- FSM states: IDLE, CHECK, WRITE, RESP.
- IDLE: arbitrate among valid requesters.
  - Only one valid: grant it.
  - Both valid: grant requester rr_ptr.
  - reqN_ready is combinational: high only in IDLE, only for the granted requester, and only while its valid is high.
  - Acceptance: on the edge where valid&ready, latch addr, wdata and id; set rr_ptr to ~id; go to CHECK.
  - No valid requester: stay in IDLE; readies stay 0.
- CHECK: compute err = lock | lock_set | (addr >= NUM_REGS).
  - lock_set is OR'ed in so that a lock arriving in the check cycle blocks the write.
  - err=1: go to RESP with resp_err pending = 1.
  - err=0: go to WRITE.
- WRITE: the latched entry takes wdata on this edge, but not if lock_set=1 this cycle; in that case nothing is written and err becomes 1.
  - Go to RESP.
  - Exactly one entry changes; all others hold.
- RESP: resp_valid=1 for exactly one cycle, with resp_id and resp_err. Return to IDLE.
  - No new grant in the RESP cycle; readies are 0.
- Latency, counting acceptance at edge T:
  - Successful write: entry updates at edge T+2 (visible in cycle T+3); resp_valid is high in cycle T+3.
  - Error: resp_valid is high in cycle T+2.
  - Minimum spacing between grants is 3 cycles (error path) or 4 cycles (write path).
- Lock:
  - Set on any edge with lock_set=1, in any state.
  - Cleared only by rst.
  - Once set, no entry can change until reset.
- Outputs are registered, except reqN_ready. reg_bank is driven directly from the entry flops.
- A requester must hold valid, addr and wdata stable until it sees ready.

Test Plan:
- Reset, then req0 write addr=2 data=0xDEADBEEF: req0_ready high in the accept cycle; entry2=0xDEADBEEF visible at T+3; resp_valid=1, resp_id=0, resp_err=0 at T+3; entries 0, 1, 3 stay 0.
- req0 and req1 both valid continuously, writing 0x11 to addr0 and 0x22 to addr1: grants alternate 0,1,0,1 starting with 0; responses arrive in the same order; no starvation.
- lock_set pulse, then writes to addr 0, 1, 2, 3 with 0xFFFFFFFF: every response has resp_err=1; all entries keep their prior values; lock stays 1 until rst.
- lock_set pulse in the CHECK cycle, and separately in the WRITE cycle, of a write of 0x5A5A5A5A: resp_err=1 and the entry is unchanged in both cases.
- NUM_REGS=3, ADDR_W=2, write to addr=3: resp_err=1 at T+2; no entry changes.
- rst asserted in the WRITE cycle: no response; all entries=0; lock=0; next request is granted to req0 when both are valid.
